mem_arbiter: RTL

Two-port arbiter that shares the single unified instruction/data memory between the multi-cycle CPU (fetch and load/store states) and a debug/loader port. It accepts one transaction at a time, drives the memory port from registered copies of the winning request, and waits a fixed read latency. It returns completion and read data to the owner. It sits between the CPU controller/datapath and the memory; the CPU FSM holds its memory state until `c_done`.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU and debug/loader), the
// arbiter and the shared instruction/data memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_done;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_done;

    logic [DW-1:0] rdata;
    logic          busy;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    // Arbiter side: takes requests and memory read data, drives everything else.
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rd,
        output c_gnt, c_done, d_gnt, d_done,
        output rdata, busy,
        output mem_addr, mem_we, mem_wd
    );

    // Requester and memory side: the mirror image of the arbiter view.
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rd,
        input  c_gnt, c_done, d_gnt, d_done,
        input  rdata, busy,
        input  mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the unified memory: the CPU and the debug/loader port
// compete for one transaction at a time, ties resolved round robin.
// The winning request is captured into registers so the memory port stays
// stable even if the requester changes its fields after the grant.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       PORT_CPU = 1'b0;
    localparam logic       PORT_DBG = 1'b1;
    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t        state_q;
    state_t        state_d;
    logic          owner_q;
    logic          last_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    cnt_q;

    logic          c_win;
    logic          d_win;
    logic          read_last;

    assign read_last = (cnt_q == CNT_LAST);

    // Arbitration in IDLE and next-state selection for the transaction FSM.
    always_comb begin
        state_d = state_q;
        c_win   = 1'b0;
        d_win   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.c_req && (!bus.d_req || last_q == PORT_DBG)) begin
                    c_win = 1'b1;
                end else if (bus.d_req) begin
                    d_win = 1'b1;
                end
                if (c_win || d_win) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q || read_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captures the winning request and counts read latency; read data is kept until the next read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= PORT_CPU;
            last_q  <= PORT_DBG;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (c_win || d_win) begin
                        owner_q <= d_win;
                        last_q  <= d_win;
                        we_q    <= d_win ? bus.d_we    : bus.c_we;
                        addr_q  <= d_win ? bus.d_addr  : bus.c_addr;
                        wd_q    <= d_win ? bus.d_wdata : bus.c_wdata;
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (read_last) begin
                            rdata_q <= bus.mem_rd;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.c_gnt    = c_win;
    assign bus.d_gnt    = d_win;
    assign bus.c_done   = (state_q == DONE) && (owner_q == PORT_CPU);
    assign bus.d_done   = (state_q == DONE) && (owner_q == PORT_DBG);
    assign bus.busy     = (state_q != IDLE);
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wd   = wd_q;
    assign bus.mem_we   = (state_q == ACCESS) && we_q;

endmodule
